bus_rr_switch: RTL and testbench

Parametrised multi-driver bus switch, the synthesisable DUT counterpart of the bus verification environment. Each of `DRVRS` drivers pushes fixed-size packets into a private FIFO of depth `FIFO_DEPTH`. A round-robin arbiter grants one FIFO head at a time onto a shared registered bus and delivers the packet to the receiver addressed in its header, or to every other driver on broadcast. Beyond the fixed bus of the previous generation, it adds:
- per-driver overflow reporting;
- invalid-address drop reporting;
- a ready/valid receive handshake.

---
 rtl/bus_rr_switch_pkg.sv | 29 ++
 rtl/bus_rr_switch_if.sv | 25 ++
 rtl/bus_sync_fifo.sv | 51 +++++
 rtl/bus_rr_switch.sv | 122 ++++++++++++
 tb/tb_bus_rr_switch.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_rr_switch_pkg.sv
// Shared types and helpers for the round-robin bus switch.
// Holds the arbiter state enum, width helpers and the rr winner search.
package bus_switch_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int MAX_DRVRS = 16;
  localparam int IDX_W = $clog2(MAX_DRVRS);
  localparam int ADDR_W_DEF = 8;
  localparam logic [ADDR_W_DEF-1:0] BROADCAST_DEF = '1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Unused request bits are zero, so a mod-16 search equals mod-DRVRS.
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [MAX_DRVRS-1:0] req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] idx;
    next_rr = last;
    for (int i = MAX_DRVRS; i >= 1; i--) begin
      idx = last + IDX_W'(i);
      if (req[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/bus_rr_switch_if.sv
// Driver/receiver bundle of the round-robin bus switch.
// master = environment side, slave = switch side.
interface bus_rr_switch_if #(
  parameter int PCKG_SZ = 16,
  parameter int DRVRS = 4
);
  logic [DRVRS-1:0]              push;
  logic [DRVRS-1:0][PCKG_SZ-1:0] din;
  logic [DRVRS-1:0]              full;
  logic [DRVRS-1:0]              ovf;
  logic [PCKG_SZ-1:0]            dout;
  logic [DRVRS-1:0]              out_valid;
  logic [DRVRS-1:0]              out_ready;
  logic                          bad_addr;

  modport master (
    output push, din, out_ready,
    input  full, ovf, dout, out_valid, bad_addr
  );

  modport slave (
    input  push, din, out_ready,
    output full, ovf, dout, out_valid, bad_addr
  );
endinterface

// File: rtl/bus_sync_fifo.sv
// Per-driver synchronous FIFO, any depth >= 2.
// Head word is visible on dout whenever the FIFO is not empty.
module bus_sync_fifo
  import bus_switch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_wr, do_rd;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  assign do_wr = push & ~full;
  assign do_rd = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr)
        wr_q <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
      if (do_rd)
        rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/bus_rr_switch.sv
// Round-robin multi-driver bus switch with per-driver FIFOs,
// unicast/broadcast decode and a ready/valid receive side.
module bus_rr_switch
  import bus_switch_pkg::*;
#(
  parameter int PCKG_SZ = 16,
  parameter int DRVRS = 4,
  parameter int FIFO_DEPTH = 10,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BROADCAST = {ADDR_W{1'b1}}
) (
  input logic           clk,
  input logic           reset,
  bus_rr_switch_if.slave bus
);
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [DRVRS-1:0]              empty_w, full_w, pop;
  logic [DRVRS-1:0][PCKG_SZ-1:0] head;
  logic [DRVRS-1:0][CW-1:0]      fifo_cnt;
  logic                          unused_cnt;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [PCKG_SZ-1:0] dout_q, dout_d;
  logic [DRVRS-1:0]   valid_q, valid_d;
  logic               bad_q, bad_d;
  logic [DRVRS-1:0]   ovf_q;

  logic [MAX_DRVRS-1:0] req;
  logic [PCKG_SZ-1:0]   hd;
  int                   g, dst;

  assign unused_cnt = ^fifo_cnt;

  for (genvar i = 0; i < DRVRS; i++) begin : g_fifo
    bus_sync_fifo #(
      .WIDTH(PCKG_SZ),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (bus.push[i]),
      .pop  (pop[i]),
      .din  (bus.din[i]),
      .dout (head[i]),
      .full (full_w[i]),
      .empty(empty_w[i]),
      .count(fifo_cnt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    bad_d   = 1'b0;
    pop     = '0;
    req     = '0;
    req[DRVRS-1:0] = ~empty_w;
    g   = int'(next_rr(req, last_q));
    hd  = '0;
    for (int j = 0; j < DRVRS; j++)
      if (j == g) hd = head[j];
    dst = int'(hd[PCKG_SZ-1 -: ADDR_W]);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          for (int j = 0; j < DRVRS; j++)
            pop[j] = (j == g);
          last_d = IDX_W'(g);
          if (dst < DRVRS) begin
            for (int j = 0; j < DRVRS; j++)
              valid_d[j] = (j == dst);
            dout_d  = hd;
            state_d = BUSY;
          end else if (hd[PCKG_SZ-1 -: ADDR_W] == BROADCAST) begin
            for (int j = 0; j < DRVRS; j++)
              valid_d[j] = (j != g);
            dout_d  = hd;
            state_d = BUSY;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Whole-set completion only; partial readiness is ignored.
        if ((valid_q & ~bus.out_ready) == '0) begin
          valid_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(DRVRS-1);
      dout_q  <= '0;
      valid_q <= '0;
      bad_q   <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      ovf_q   <= bus.push & full_w;
    end
  end

  assign bus.full      = full_w;
  assign bus.ovf       = ovf_q;
  assign bus.dout      = dout_q;
  assign bus.out_valid = valid_q;
  assign bus.bad_addr  = bad_q;
endmodule

// File: tb/tb_bus_rr_switch.sv
// Self-checking bench for bus_rr_switch: directed scenarios plus
// a randomized run against a queue-based transaction model.
module tb_bus_rr_switch;
  localparam int N = 4;
  localparam int D = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  bus_rr_switch_if #(.PCKG_SZ(16), .DRVRS(N)) bif ();

  bus_rr_switch #(
    .PCKG_SZ(16), .DRVRS(N), .FIFO_DEPTH(D), .ADDR_W(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.push = '0;
    bif.din = '0;
    bif.out_ready = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Transaction-level reference model
  logic [15:0] mq [N][$];
  int          m_last;
  bit          m_busy;
  logic [3:0]  m_valid;
  logic [15:0] m_dout;
  logic        m_bad;
  logic [3:0]  m_ovf;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_last = N - 1;
    m_busy = 0;
    m_valid = '0;
    m_dout = '0;
    m_bad = 0;
    m_ovf = '0;
  endfunction

  function automatic void model_step(
    input logic [3:0] psh,
    input logic [3:0][15:0] dn,
    input logic [3:0] rdy
  );
    bit fullpre [N];
    int w;
    logic [15:0] pkt;
    int dst;
    for (int i = 0; i < N; i++) fullpre[i] = (mq[i].size() == D);
    m_bad = 0;
    if (m_busy) begin
      if ((m_valid & ~rdy) == 4'b0) begin
        m_valid = '0;
        m_busy = 0;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && mq[(m_last + k) % N].size() > 0) w = (m_last + k) % N;
      if (w >= 0) begin
        pkt = mq[w].pop_front();
        m_last = w;
        dst = int'(pkt[15:8]);
        if (dst < N) begin
          m_valid = 4'(1 << dst);
          m_dout = pkt;
          m_busy = 1;
        end else if (dst == 255) begin
          m_valid = 4'hF & ~4'(1 << w);
          m_dout = pkt;
          m_busy = 1;
        end else begin
          m_bad = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_ovf[i] = psh[i] && fullpre[i];
      if (psh[i] && !fullpre[i]) mq[i].push_back(dn[i]);
    end
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks += 5;
    if (bif.full !== 4'h0) begin
      n_errors++; $display("FAIL reset_full got %h exp 0", bif.full);
    end
    if (bif.ovf !== 4'h0) begin
      n_errors++; $display("FAIL reset_ovf got %h exp 0", bif.ovf);
    end
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL reset_valid got %h exp 0", bif.out_valid);
    end
    if (bif.dout !== 16'h0) begin
      n_errors++; $display("FAIL reset_dout got %h exp 0", bif.dout);
    end
    if (bif.bad_addr !== 1'b0) begin
      n_errors++; $display("FAIL reset_bad got %b exp 0", bif.bad_addr);
    end
  endtask

  task automatic test_single();
    do_reset();
    bif.out_ready = 4'hF;
    bif.push = 4'b0010;
    bif.din[1] = 16'h0203;
    cyc();
    bif.push = '0;
    n_checks++;
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL single_early got %h exp 0", bif.out_valid);
    end
    cyc();
    n_checks += 2;
    if (bif.out_valid !== 4'b0100) begin
      n_errors++; $display("FAIL single_valid got %h exp 4", bif.out_valid);
    end
    if (bif.dout !== 16'h0203) begin
      n_errors++; $display("FAIL single_dout got %h exp 0203", bif.dout);
    end
    cyc();
    n_checks++;
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL single_clear got %h exp 0", bif.out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bif.out_ready = 4'hF;
    bif.push = 4'hF;
    for (int i = 0; i < N; i++) bif.din[i] = 16'h00A0 + 16'(i);
    cyc();
    bif.push = '0;
    for (int i = 0; i < N; i++) begin
      cyc();
      n_checks += 2;
      if (bif.out_valid !== 4'b0001) begin
        n_errors++; $display("FAIL rr_valid%0d got %h exp 1", i, bif.out_valid);
      end
      if (bif.dout !== 16'h00A0 + 16'(i)) begin
        n_errors++; $display("FAIL rr_order%0d got %h exp %h", i, bif.dout, 16'h00A0 + 16'(i));
      end
      cyc();
      n_checks++;
      if (bif.out_valid !== 4'h0) begin
        n_errors++; $display("FAIL rr_gap%0d got %h exp 0", i, bif.out_valid);
      end
    end
  endtask

  task automatic test_broadcast_stall();
    do_reset();
    bif.out_ready = 4'b0011;
    bif.push = 4'b0100;
    bif.din[2] = 16'hFF55;
    cyc();
    bif.push = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks += 2;
      if (bif.out_valid !== 4'b1011) begin
        n_errors++; $display("FAIL bc_hold%0d got %h exp b", i, bif.out_valid);
      end
      if (bif.dout !== 16'hFF55) begin
        n_errors++; $display("FAIL bc_dout%0d got %h exp ff55", i, bif.dout);
      end
    end
    bif.out_ready = 4'hF;
    cyc();
    n_checks++;
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL bc_done got %h exp 0", bif.out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bif.push = 4'b0001;
    bif.din[0] = 16'h0199;
    cyc();
    bif.push = '0;
    for (int i = 0; i <= D; i++) begin
      bif.push = 4'b1000;
      bif.din[3] = {8'h00, 8'h30 + 8'(i)};
      cyc();
      n_checks += 2;
      if (bif.full[3] !== (i >= D - 1)) begin
        n_errors++; $display("FAIL ovf_full%0d got %b exp %b", i, bif.full[3], i >= D - 1);
      end
      if (bif.ovf[3] !== (i == D)) begin
        n_errors++; $display("FAIL ovf_pulse%0d got %b exp %b", i, bif.ovf[3], i == D);
      end
    end
    bif.push = '0;
    cyc();
    n_checks++;
    if (bif.ovf !== 4'h0) begin
      n_errors++; $display("FAIL ovf_once got %h exp 0", bif.ovf);
    end
    bif.out_ready = 4'hF;
    cyc();
    n_checks++;
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL ovf_pre got %h exp 0", bif.out_valid);
    end
    for (int i = 0; i < D; i++) begin
      cyc();
      n_checks += 3;
      if (bif.out_valid !== 4'b0001) begin
        n_errors++; $display("FAIL ovf_valid%0d got %h exp 1", i, bif.out_valid);
      end
      if (bif.dout !== {8'h00, 8'h30 + 8'(i)}) begin
        n_errors++; $display("FAIL ovf_data%0d got %h exp %h", i, bif.dout, {8'h00, 8'h30 + 8'(i)});
      end
      if (bif.full[3] !== 1'b0) begin
        n_errors++; $display("FAIL ovf_fall%0d got %b exp 0", i, bif.full[3]);
      end
      cyc();
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    bif.out_ready = 4'hF;
    bif.push = 4'b0011;
    bif.din[0] = 16'h0711;
    bif.din[1] = 16'h0122;
    cyc();
    bif.push = '0;
    cyc();
    n_checks += 2;
    if (bif.bad_addr !== 1'b1) begin
      n_errors++; $display("FAIL bad_pulse got %b exp 1", bif.bad_addr);
    end
    if (bif.out_valid !== 4'h0) begin
      n_errors++; $display("FAIL bad_valid got %h exp 0", bif.out_valid);
    end
    cyc();
    n_checks += 3;
    if (bif.bad_addr !== 1'b0) begin
      n_errors++; $display("FAIL bad_once got %b exp 0", bif.bad_addr);
    end
    if (bif.out_valid !== 4'b0010) begin
      n_errors++; $display("FAIL bad_next got %h exp 2", bif.out_valid);
    end
    if (bif.dout !== 16'h0122) begin
      n_errors++; $display("FAIL bad_dout got %h exp 0122", bif.dout);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    bif.push = 4'b0110;
    bif.din[1] = 16'h0300;
    bif.din[2] = 16'h0011;
    cyc();
    bif.push = '0;
    cyc();
    n_checks++;
    if (bif.out_valid !== 4'b1000) begin
      n_errors++; $display("FAIL mid_held got %h exp 8", bif.out_valid);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++;
    if ({bif.full, bif.ovf, bif.out_valid, bif.dout, bif.bad_addr} !== 29'h0) begin
      n_errors++; $display("FAIL mid_reset got %h exp 0",
        {bif.full, bif.ovf, bif.out_valid, bif.dout, bif.bad_addr});
    end
    bif.out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (bif.out_valid !== 4'h0 || bif.bad_addr !== 1'b0) begin
        n_errors++; $display("FAIL mid_stale%0d got %h/%b exp 0/0", i, bif.out_valid, bif.bad_addr);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] psh, rdy;
    logic [3:0][15:0] dn;
    int r, pct;
    logic [7:0] dst;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      pct = (c < 400) ? 50 : 15;
      for (int i = 0; i < N; i++) begin
        psh[i] = ($urandom_range(0, 99) < pct);
        rdy[i] = ($urandom_range(0, 99) < 65);
        r = $urandom_range(0, 9);
        if (r < 6) dst = 8'(r % N);
        else if (r < 8) dst = 8'hFF;
        else dst = 8'($urandom_range(N, 254));
        dn[i] = {dst, 8'($urandom)};
      end
      bif.push = psh;
      bif.din = dn;
      bif.out_ready = rdy;
      cyc();
      model_step(psh, dn, rdy);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (bif.full[i] !== (mq[i].size() == D)) begin
          n_errors++; $display("FAIL rnd_full c%0d d%0d got %b exp %b", c, i, bif.full[i], mq[i].size() == D);
        end
      end
      n_checks += 3;
      if (bif.ovf !== m_ovf) begin
        n_errors++; $display("FAIL rnd_ovf c%0d got %h exp %h", c, bif.ovf, m_ovf);
      end
      if (bif.out_valid !== m_valid) begin
        n_errors++; $display("FAIL rnd_valid c%0d got %h exp %h", c, bif.out_valid, m_valid);
      end
      if (bif.bad_addr !== m_bad) begin
        n_errors++; $display("FAIL rnd_bad c%0d got %b exp %b", c, bif.bad_addr, m_bad);
      end
      if (m_valid != 4'h0) begin
        n_checks++;
        if (bif.dout !== m_dout) begin
          n_errors++; $display("FAIL rnd_dout c%0d got %h exp %h", c, bif.dout, m_dout);
        end
      end
    end
  endtask

  initial begin
    bif.push = '0;
    bif.din = '0;
    bif.out_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_broadcast_stall();
    test_overflow();
    test_bad_addr();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
